// File: rtl/sipo_pkg.sv
// Shared constants, types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    typedef enum logic {
        SHIFT_LSB_FIRST = 1'b0,
        SHIFT_MSB_FIRST = 1'b1
    } shift_order_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    function automatic shift_order_e order_of(input bit msb_first);
        return msb_first ? SHIFT_MSB_FIRST : SHIFT_LSB_FIRST;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    logic             s_in;
    logic             s_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             p_ready;

    modport master (
        input  s_in,
        input  s_valid,
        input  p_ready,
        output p_data,
        output p_valid
    );

    modport slave (
        output s_in,
        output s_valid,
        output p_ready,
        input  p_data,
        input  p_valid
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Enabled shift register with selectable shift direction and synchronous clear.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int           WIDTH = SIPO_DEFAULT_WIDTH,
    parameter shift_order_e ORDER = SHIFT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = q;
        if (ORDER == SHIFT_MSB_FIRST)
            nxt = {q[WIDTH-2:0], din};
        else
            nxt = {din, q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: bit counter, holding register, output handshake
// and sticky overrun on top of the shift core.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    sipo_deser_if.master            bus,
    output logic [cnt_w(WIDTH)-1:0] bit_cnt,
    output logic                    overrun
);

    localparam int           CW    = cnt_w(WIDTH);
    localparam shift_order_e ORDER = order_of(MSB_FIRST);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    logic             ovr_q;
    logic             take;
    logic             done;
    logic             load;
    logic             drop;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (take),
        .din   (bus.s_in),
        .q     (sr),
        .nxt   (sr_nxt)
    );

    // clr discards the sampled bit, so it also suppresses completion
    assign take = bus.s_valid && !clr;
    assign done = take && (cnt_q == CW'(WIDTH - 1));
    assign load = done && (!valid_q || bus.p_ready);
    assign drop = done && valid_q && !bus.p_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (take) begin
            cnt_q <= done ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= sr_nxt;
            valid_q <= 1'b1;
        end else if (valid_q && bus.p_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_q <= 1'b0;
        else if (clr)
            ovr_q <= 1'b0;
        else if (drop)
            ovr_q <= 1'b1;
    end

    assign bus.p_data  = data_q;
    assign bus.p_valid = valid_q;
    assign bit_cnt     = cnt_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench: MSB-first and LSB-first deserializers share one
// randomized bit stream and are checked against a queue-based model.
module tb_sipo_deser;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic clr;
    logic [2:0] cnt_m;
    logic [2:0] cnt_l;
    logic ovr_m;
    logic ovr_l;

    sipo_deser_if #(.WIDTH(W)) bm ();
    sipo_deser_if #(.WIDTH(W)) bl ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bm),
        .bit_cnt (cnt_m),
        .overrun (ovr_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bl),
        .bit_cnt (cnt_l),
        .overrun (ovr_l)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit         bits[$];
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    bit         m_full = 0;
    bit         m_ovr  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        exp_m.delete();
        exp_l.delete();
        m_full = 0;
        m_ovr  = 0;
    endtask

    task automatic model_edge(input bit b, input bit v, input bit pr,
                              input bit c);
        logic [7:0] wm;
        logic [7:0] wl;
        bit complete;
        complete = 0;
        wm = '0;
        wl = '0;
        if (c) begin
            bits.delete();
            m_ovr = 0;
        end else if (v) begin
            bits.push_back(b);
            if (bits.size() == W) begin
                complete = 1;
                for (int i = 0; i < W; i++) begin
                    wm = wm + (8'(bits[i]) << (W - 1 - i));
                    wl = wl + (8'(bits[i]) << i);
                end
                bits.delete();
            end
        end
        if (complete && (!m_full || pr)) begin
            exp_m.push_back(wm);
            exp_l.push_back(wl);
            m_full = 1;
        end else if (complete) begin
            m_ovr = 1;
        end else if (m_full && pr) begin
            m_full = 0;
        end
    endtask

    task automatic drive(input bit b, input bit v, input bit pr, input bit c);
        bm.s_in = b;  bl.s_in = b;
        bm.s_valid = v; bl.s_valid = v;
        bm.p_ready = pr; bl.p_ready = pr;
        clr = c;
        @(posedge clk);
        model_edge(b, v, pr, c);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit pr, input bit gap);
        for (int i = W - 1; i >= 0; i--) begin
            drive(w[i], 1'b1, pr, 1'b0);
            if (gap) drive(1'b0, 1'b0, pr, 1'b0);
        end
    endtask

    // monitor: per-cycle state compare and scoreboard pop on acceptance
    always @(negedge clk) begin
        if (rst_n) begin
            chk("bit_cnt_m", 64'(cnt_m), 64'(bits.size()));
            chk("bit_cnt_l", 64'(cnt_l), 64'(bits.size()));
            chk("overrun_m", 64'(ovr_m), 64'(m_ovr));
            chk("p_valid_m", 64'(bm.p_valid), 64'(m_full));
            chk("p_valid_l", 64'(bl.p_valid), 64'(m_full));
            if (bm.p_valid && bm.p_ready) begin
                if (exp_m.size() == 0) begin
                    chk("pop_empty", 64'(1), 64'(0));
                end else begin
                    chk("p_data_m", 64'(bm.p_data), 64'(exp_m.pop_front()));
                    chk("p_data_l", 64'(bl.p_data), 64'(exp_l.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        bm.s_in = 0; bm.s_valid = 0; bm.p_ready = 0;
        bl.s_in = 0; bl.s_valid = 0; bl.p_ready = 0;
        #3;
        chk("rst_p_data", 64'(bm.p_data), 64'h0);
        chk("rst_p_valid", 64'(bm.p_valid), 64'h0);
        chk("rst_bit_cnt", 64'(cnt_m), 64'h0);
        chk("rst_overrun", 64'(ovr_m), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single word, held so the holding register can be inspected
        send_word(8'hB4, 1'b0, 1'b0);
        chk("b4_msb", 64'(bm.p_data), 64'hB4);
        chk("b4_lsb", 64'(bl.p_data), 64'h2D);
        chk("b4_cnt", 64'(cnt_m), 64'h0);
        drive(0, 0, 1, 0);

        // gapped stream
        send_word(8'hB4, 1'b0, 1'b1);
        chk("gap_msb", 64'(bm.p_data), 64'hB4);
        drive(0, 0, 1, 0);

        // back-to-back with ready high
        send_word(8'hB4, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b0);
        chk("b2b_ovr", 64'(ovr_m), 64'h0);
        drive(0, 0, 1, 0);

        // overrun with ready low
        send_word(8'hB4, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("ovr_set", 64'(ovr_m), 64'h1);
        send_word(8'hFF, 1'b0, 1'b0);
        chk("ovr_hold_data", 64'(bm.p_data), 64'hB4);
        drive(0, 0, 1, 0);
        chk("ovr_valid_drop", 64'(bm.p_valid), 64'h0);
        drive(0, 0, 0, 1);
        chk("ovr_clr", 64'(ovr_m), 64'h0);

        // asynchronous reset mid-word
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 0);
        chk("mid_cnt", 64'(cnt_m), 64'h5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_cnt", 64'(cnt_m), 64'h0);
        chk("arst_valid", 64'(bm.p_valid), 64'h0);
        chk("arst_data", 64'(bm.p_data), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0);
        chk("post_rst_msb", 64'(bm.p_data), 64'h5A);
        chk("post_rst_lsb", 64'(bl.p_data), 64'h5A);
        drive(0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++)
            drive(1'($urandom % 2), ($urandom % 10) < 7,
                  1'($urandom % 2), ($urandom % 40) == 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        chk("drain_empty", 64'(exp_m.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
